// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_e;

    localparam int TCNT_W = 8;

    // Width needed to hold a data-grant streak count of 0..smax.
    function automatic int streak_width(input int smax);
        return (smax < 1) ? 1 : $clog2(smax + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between fetch and data requests.
// Data normally wins; fetch is forced through once data has taken
// STARVE_MAX consecutive grants while a live fetch was waiting.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int SW         = streak_width(STARVE_MAX)
) (
    input  logic          if_req,
    input  logic          if_flush,
    input  logic          d_req,
    input  logic [SW-1:0] d_streak,
    output logic          if_live,
    output logic          forced,
    output logic          grant_d,
    output logic          grant_if
);

    // A flushed fetch is not a candidate this cycle.
    assign if_live  = if_req & ~if_flush;
    assign forced   = if_live & d_req & (d_streak == SW'(STARVE_MAX));
    assign grant_d  = d_req & ~forced;
    assign grant_if = if_live & ~grant_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between
// instruction fetch and the MEM stage.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_IDLE  | no transaction; pick a winner and launch m_req
// ARB_BUSY  | m_req held with stable fields until m_ack or timeout
// ARB_RESP  | owner's one-cycle ack (fetch ack dropped if flushed)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              if_stall,
    output logic              d_stall,
    output logic              err_timeout
);

    localparam int SW = streak_width(STARVE_MAX);

    arb_state_e        state_q;
    arb_owner_e        owner_q;
    logic [SW-1:0]     d_streak_q;
    logic [TCNT_W-1:0] tcnt_q;
    logic              flush_pend_q;
    logic              m_req_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              if_ack_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              d_ack_q;
    logic              err_q;

    logic if_live;
    logic forced;
    logic grant_d;
    logic grant_if;
    logic if_dropped;
    logic timeout_hit;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_pick (
        .if_req   (if_req),
        .if_flush (if_flush),
        .d_req    (d_req),
        .d_streak (d_streak_q),
        .if_live  (if_live),
        .forced   (forced),
        .grant_d  (grant_d),
        .grant_if (grant_if)
    );

    // A fetch whose flush arrives in the completing cycle is dropped too.
    assign if_dropped  = flush_pend_q | if_flush;
    // tcnt counts stalled BUSY cycles; reaching TIMEOUT on this cycle's
    // increment ends the transaction, so m_req lasts exactly TIMEOUT cycles.
    assign timeout_hit = (tcnt_q == TCNT_W'(TIMEOUT - 1));

    // Arbiter FSM with counters and all registered datapath outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_NONE;
            d_streak_q   <= '0;
            tcnt_q       <= '0;
            flush_pend_q <= 1'b0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            if_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            d_rdata_q    <= '0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    flush_pend_q <= 1'b0;
                    tcnt_q       <= '0;
                    if (grant_d) begin
                        m_req_q    <= 1'b1;
                        m_we_q     <= d_we;
                        m_addr_q   <= d_addr;
                        m_wdata_q  <= d_wdata;
                        owner_q    <= OWN_D;
                        state_q    <= ARB_BUSY;
                        d_streak_q <= if_live ? d_streak_q + SW'(1) : '0;
                    end else if (grant_if) begin
                        m_req_q    <= 1'b1;
                        m_we_q     <= 1'b0;
                        m_addr_q   <= if_addr;
                        m_wdata_q  <= '0;
                        owner_q    <= OWN_IF;
                        state_q    <= ARB_BUSY;
                        d_streak_q <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (if_flush) flush_pend_q <= 1'b1;
                    if (m_ack) begin
                        m_req_q <= 1'b0;
                        tcnt_q  <= '0;
                        state_q <= ARB_RESP;
                        if (owner_q == OWN_D) begin
                            d_rdata_q <= m_we_q ? '0 : m_rdata;
                            d_ack_q   <= 1'b1;
                        end else if (!if_dropped) begin
                            if_rdata_q <= m_rdata;
                            if_ack_q   <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        m_req_q <= 1'b0;
                        tcnt_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= ARB_RESP;
                        if (owner_q == OWN_D) begin
                            d_rdata_q <= '0;
                            d_ack_q   <= 1'b1;
                        end else if (!if_dropped) begin
                            if_rdata_q <= '0;
                            if_ack_q   <= 1'b1;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                    end
                end
                ARB_RESP: begin
                    tcnt_q  <= '0;
                    owner_q <= OWN_NONE;
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                    owner_q <= OWN_NONE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_req       = m_req_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign if_rdata    = if_rdata_q;
    // A flush arriving during the ack cycle itself still cancels the ack.
    assign if_ack      = if_ack_q & ~if_flush;
    assign d_rdata     = d_rdata_q;
    assign d_ack       = d_ack_q;
    assign err_timeout = err_q;
    assign if_stall    = if_req & ~if_ack & ~if_flush;
    assign d_stall     = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants
// and acks into queues; a monitor pops and compares as the DUT presents them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, d_req, d_we;
    logic [63:0] if_addr, d_addr, d_wdata;
    logic [63:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic        if_ack, d_ack, m_req, m_we, m_ack, if_stall, d_stall, err_timeout;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } grant_t;

    grant_t      exp_g[$];
    logic [63:0] exp_d[$];
    logic [63:0] exp_if[$];

    int n_checks = 0;
    int n_pass   = 0;
    int mem_lat  = 1;
    int mcyc     = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .if_stall(if_stall), .d_stall(d_stall), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rdata_of(input logic [63:0] a);
        if (a == 64'h40) return 64'hDEAD;
        return {~a[31:0], a[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_g(input logic we, input logic [63:0] a, input logic [63:0] wd);
        grant_t g;
        g.we = we; g.addr = a; g.wdata = wd;
        exp_g.push_back(g);
    endtask

    // Waits for the chosen ack; cyc is the negedge index it appeared on, or -1.
    task automatic wait_ack(input bit want_if, input int budget, output int cyc, output bit other_seen);
        cyc = -1;
        other_seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (want_if ? d_ack : if_ack) other_seen = 1'b1;
            if (want_if ? if_ack : d_ack) begin
                cyc = c;
                break;
            end
        end
    endtask

    // Memory model: acks in the mem_lat-th cycle of m_req (0 = never).
    initial begin
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m_req) begin
                mcyc++;
                if (mem_lat > 0 && mcyc == mem_lat) begin
                    m_ack = 1'b1;
                    m_rdata = rdata_of(m_addr);
                end else begin
                    m_ack = 1'b0;
                    m_rdata = '0;
                end
            end else begin
                mcyc = 0;
                m_ack = 1'b0;
            end
        end
    end

    // Monitor: compares every new grant and every ack against the queues.
    initial begin
        grant_t      g;
        logic [63:0] e;
        logic        m_req_prev;
        m_req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_req && !m_req_prev) begin
                    if (exp_g.size() == 0) chk("grant_unexpected", m_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                    else begin
                        g = exp_g.pop_front();
                        chk("grant_we", 64'(m_we), 64'(g.we));
                        chk("grant_addr", m_addr, g.addr);
                        if (g.we) chk("grant_wdata", m_wdata, g.wdata);
                    end
                end
                if (d_ack) begin
                    if (exp_d.size() == 0) chk("d_ack_unexpected", 64'(d_ack), 64'd0);
                    else begin
                        e = exp_d.pop_front();
                        chk("d_rdata", d_rdata, e);
                    end
                end
                if (if_ack) begin
                    if (exp_if.size() == 0) chk("if_ack_unexpected", 64'(if_ack), 64'd0);
                    else begin
                        e = exp_if.pop_front();
                        chk("if_rdata", if_rdata, e);
                    end
                end
            end
            m_req_prev = m_req;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        bit          other;
        int          cnt;
        bit          seen;
        logic [63:0] a;

        rst_n = 1'b0;
        if_req = 0; if_addr = '0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_m_req", 64'(m_req), 64'd0);
        chk("rst_m_addr", m_addr, 64'd0);
        chk("rst_if_ack", 64'(if_ack), 64'd0);
        chk("rst_d_ack", 64'(d_ack), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Single load, m_ack in cycle 3, ack in cycle 4.
        mem_lat = 3;
        d_we = 0; d_addr = 64'h40; d_req = 1;
        push_g(1'b0, 64'h40, 64'h0);
        exp_d.push_back(64'hDEAD);
        cyc = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d_ack) begin
                cyc = c;
                break;
            end
            chk("t1_d_stall", 64'(d_stall), 64'd1);
            if (c >= 1) begin
                chk("t1_m_req", 64'(m_req), 64'd1);
                chk("t1_m_addr", m_addr, 64'h40);
            end else chk("t1_m_req_c0", 64'(m_req), 64'd0);
        end
        chk("t1_ack_cycle", 64'(cyc), 64'd4);
        chk("t1_d_stall_at_ack", 64'(d_stall), 64'd0);
        tick();
        d_req = 0;
        repeat (2) tick();

        // Contention: 4 data grants, forced fetch, then data again.
        mem_lat = 1;
        if_addr = 64'h200; if_req = 1;
        d_addr = 64'h80; d_req = 1;
        for (int i = 0; i < 4; i++) begin
            a = 64'h80 + 64'(i * 8);
            push_g(1'b0, a, 64'h0);
            exp_d.push_back(rdata_of(a));
        end
        push_g(1'b0, 64'h200, 64'h0);
        exp_if.push_back(rdata_of(64'h200));
        push_g(1'b0, 64'hA0, 64'h0);
        exp_d.push_back(rdata_of(64'hA0));
        for (int i = 0; i < 4; i++) begin
            wait_ack(1'b0, 20, cyc, other);
            chk("t2_d_ack_seen", 64'(cyc >= 0), 64'd1);
            chk("t2_if_stall", 64'(if_stall), 64'd1);
            tick();
            d_addr = 64'h88 + 64'(i * 8);
        end
        wait_ack(1'b1, 20, cyc, other);
        chk("t2_if_ack_seen", 64'(cyc >= 0), 64'd1);
        chk("t2_no_d_ack_before_if", 64'(other), 64'd0);
        tick();
        if_req = 0;
        wait_ack(1'b0, 20, cyc, other);
        chk("t2_last_d_ack_seen", 64'(cyc >= 0), 64'd1);
        tick();
        d_req = 0;
        repeat (2) tick();

        // Store: write fields driven, read data returns 0, no fetch ack.
        mem_lat = 2;
        d_we = 1; d_addr = 64'h300; d_wdata = 64'h1234; d_req = 1;
        push_g(1'b1, 64'h300, 64'h1234);
        exp_d.push_back(64'h0);
        wait_ack(1'b0, 20, cyc, other);
        chk("t3_d_ack_cycle", 64'(cyc), 64'd3);
        chk("t3_if_ack", 64'(other), 64'd0);
        tick();
        d_req = 0; d_we = 0;
        repeat (2) tick();

        // Flush of an in-flight fetch: memory completes, no fetch ack.
        mem_lat = 3;
        if_addr = 64'h100; if_req = 1;
        push_g(1'b0, 64'h100, 64'h0);
        cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin
                if_flush = 1; if_req = 0;
            end
            if (c == 3) if_flush = 0;
            @(negedge clk);
            if (m_req) cnt++;
            if (if_ack) seen = 1'b1;
            tick();
        end
        chk("t4_m_req_cycles", 64'(cnt), 64'd3);
        chk("t4_if_ack", 64'(seen), 64'd0);
        chk("t4_if_rdata_kept", if_rdata, rdata_of(64'h200));
        mem_lat = 1;
        d_addr = 64'h48; d_req = 1;
        push_g(1'b0, 64'h48, 64'h0);
        exp_d.push_back(rdata_of(64'h48));
        wait_ack(1'b0, 20, cyc, other);
        chk("t4_next_load_cycle", 64'(cyc), 64'd2);
        tick();
        d_req = 0;
        repeat (2) tick();

        // Timeout: no m_ack at all.
        mem_lat = 0;
        chk("t5_err_before", 64'(err_timeout), 64'd0);
        d_addr = 64'h500; d_req = 1;
        push_g(1'b0, 64'h500, 64'h0);
        exp_d.push_back(64'h0);
        cnt = 0;
        cyc = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (m_req) cnt++;
            if (d_ack) begin
                cyc = c;
                break;
            end
        end
        chk("t5_m_req_cycles", 64'(cnt), 64'd255);
        chk("t5_ack_cycle", 64'(cyc), 64'd256);
        chk("t5_err_at_ack", 64'(err_timeout), 64'd1);
        tick();
        d_req = 0;
        mem_lat = 1;
        repeat (5) tick();
        chk("t5_err_sticky", 64'(err_timeout), 64'd1);

        // Asynchronous reset in the middle of BUSY.
        mem_lat = 10;
        d_addr = 64'h600; d_req = 1;
        push_g(1'b0, 64'h600, 64'h0);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_m_req_async", 64'(m_req), 64'd0);
        chk("t6_d_ack_async", 64'(d_ack), 64'd0);
        chk("t6_err_async", 64'(err_timeout), 64'd0);
        chk("t6_m_addr_async", m_addr, 64'd0);
        d_req = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d_ack || if_ack || m_req) seen = 1'b1;
        end
        chk("t6_quiet_after_reset", 64'(seen), 64'd0);

        chk("end_exp_g_empty", 64'(exp_g.size()), 64'd0);
        chk("end_exp_d_empty", 64'(exp_d.size()), 64'd0);
        chk("end_exp_if_empty", 64'(exp_if.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
